decode_cycle: RTL and testbench

Second pipeline stage of the RV32I processor. It consumes the fetch stage's IF/ID outputs (instrD, pcD, pcincr4D) and holds the 32x32 register file. It decodes control fields, generates the immediate and registers everything into the ID/EX pipeline register for the execute stage. The write-back port returns results from the W stage, and the hazard unit drives flushE.

---
 rtl/decode_cycle.sv | 149 ++++++++++++++
 tb/tb_decode_cycle.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_cycle.sv
// RV32I decode stage: register file, control/ALU decode, immediate generation
// and the ID/EX pipeline register feeding execute.
module decode_cycle #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instrD,
    input  logic [XLEN-1:0] pcD,
    input  logic [XLEN-1:0] pcincr4D,
    input  logic            regwriteW,
    input  logic [4:0]      rdW,
    input  logic [XLEN-1:0] resultW,
    input  logic            flushE,
    output logic [4:0]      rs1D,
    output logic [4:0]      rs2D,
    output logic            regwriteE,
    output logic [1:0]      resultsrcE,
    output logic            memwriteE,
    output logic            jumpE,
    output logic            branchE,
    output logic [2:0]      alucontrolE,
    output logic            alusrcE,
    output logic [XLEN-1:0] rd1E,
    output logic [XLEN-1:0] rd2E,
    output logic [XLEN-1:0] immextE,
    output logic [XLEN-1:0] pcE,
    output logic [XLEN-1:0] pcincr4E,
    output logic [4:0]      rdE,
    output logic [4:0]      rs1E,
    output logic [4:0]      rs2E
);
    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW  = 7'b0100011, OP_R   = 7'b0110011,
                           OP_I  = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                           ALU_OR  = 3'b011, ALU_SLT = 3'b101;

    logic [XLEN-1:0] rf_q [NREGS];
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rd1_d, rd2_d, imm_d;
    logic            regwrite_d, memwrite_d, jump_d, branch_d, alusrc_d;
    logic [1:0]      resultsrc_d;
    logic [2:0]      alucontrol_d;

    assign opcode = instrD[6:0];
    assign funct3 = instrD[14:12];
    assign rs1D   = instrD[19:15];
    assign rs2D   = instrD[24:20];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (regwriteW && rdW != 5'd0) begin
            rf_q[rdW] <= resultW;
        end
    end

    // Same-cycle write-back bypass so ID/EX never captures a stale operand.
    always_comb begin
        rd1_d = rf_q[rs1D];
        rd2_d = rf_q[rs2D];
        if (regwriteW && rdW == rs1D) rd1_d = resultW;
        if (regwriteW && rdW == rs2D) rd2_d = resultW;
        if (rs1D == 5'd0) rd1_d = '0;
        if (rs2D == 5'd0) rd2_d = '0;
    end

    always_comb begin
        regwrite_d   = 1'b0;
        memwrite_d   = 1'b0;
        jump_d       = 1'b0;
        branch_d     = 1'b0;
        alusrc_d     = 1'b0;
        resultsrc_d  = 2'b00;
        alucontrol_d = ALU_ADD;
        imm_d        = '0;
        case (opcode)
            OP_LW: begin
                regwrite_d  = 1'b1;
                resultsrc_d = 2'b01;
                alusrc_d    = 1'b1;
                imm_d       = {{(XLEN-12){instrD[31]}}, instrD[31:20]};
            end
            OP_SW: begin
                memwrite_d = 1'b1;
                alusrc_d   = 1'b1;
                imm_d      = {{(XLEN-12){instrD[31]}}, instrD[31:25], instrD[11:7]};
            end
            OP_R, OP_I: begin
                regwrite_d = 1'b1;
                alusrc_d   = (opcode == OP_I);
                if (opcode == OP_I) imm_d = {{(XLEN-12){instrD[31]}}, instrD[31:20]};
                case (funct3)
                    3'b000:  alucontrol_d = (opcode == OP_R && instrD[30]) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol_d = ALU_SLT;
                    3'b110:  alucontrol_d = ALU_OR;
                    3'b111:  alucontrol_d = ALU_AND;
                    default: alucontrol_d = ALU_ADD;
                endcase
            end
            OP_BEQ: begin
                branch_d     = 1'b1;
                alucontrol_d = ALU_SUB;
                imm_d        = {{(XLEN-12){instrD[31]}}, instrD[7], instrD[30:25], instrD[11:8], 1'b0};
            end
            OP_JAL: begin
                regwrite_d  = 1'b1;
                jump_d      = 1'b1;
                resultsrc_d = 2'b10;
                imm_d       = {{(XLEN-20){instrD[31]}}, instrD[19:12], instrD[20], instrD[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    // Flush clears control and register ids only; data fields load regardless.
    always_ff @(posedge clk) begin
        if (rst) begin
            regwriteE <= 1'b0; resultsrcE <= 2'b00; memwriteE <= 1'b0; jumpE <= 1'b0;
            branchE <= 1'b0; alucontrolE <= 3'b000; alusrcE <= 1'b0;
            rd1E <= '0; rd2E <= '0; immextE <= '0; pcE <= '0; pcincr4E <= '0;
            rdE <= '0; rs1E <= '0; rs2E <= '0;
        end else begin
            rd1E     <= rd1_d;
            rd2E     <= rd2_d;
            immextE  <= imm_d;
            pcE      <= pcD;
            pcincr4E <= pcincr4D;
            if (flushE) begin
                regwriteE <= 1'b0; resultsrcE <= 2'b00; memwriteE <= 1'b0; jumpE <= 1'b0;
                branchE <= 1'b0; alucontrolE <= 3'b000; alusrcE <= 1'b0;
                rdE <= '0; rs1E <= '0; rs2E <= '0;
            end else begin
                regwriteE   <= regwrite_d;
                resultsrcE  <= resultsrc_d;
                memwriteE   <= memwrite_d;
                jumpE       <= jump_d;
                branchE     <= branch_d;
                alucontrolE <= alucontrol_d;
                alusrcE     <= alusrc_d;
                rdE         <= instrD[11:7];
                rs1E        <= rs1D;
                rs2E        <= rs2D;
            end
        end
    end
endmodule

// File: tb/tb_decode_cycle.sv
// Randomized bench for decode_cycle against an arithmetic reference model,
// plus directed cases for reset, immediates, write-through and flush.
module tb_decode_cycle;
    logic        clk = 1'b0;
    logic        rst, regwriteW, flushE;
    logic [31:0] instrD, pcD, pcincr4D, resultW;
    logic [4:0]  rdW, rs1D, rs2D;
    logic        regwriteE, memwriteE, jumpE, branchE, alusrcE;
    logic [1:0]  resultsrcE;
    logic [2:0]  alucontrolE;
    logic [31:0] rd1E, rd2E, immextE, pcE, pcincr4E;
    logic [4:0]  rdE, rs1E, rs2E;

    int errors = 0, checks = 0;
    logic [31:0] mrf [32];

    typedef struct {
        logic regw, memw, jump, branch, asrc;
        logic [1:0] rsrc;
        logic [2:0] alu;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0] rd, rs1, rs2;
    } exp_t;

    always #5 clk = ~clk;

    decode_cycle dut (
        .clk(clk), .rst(rst), .instrD(instrD), .pcD(pcD), .pcincr4D(pcincr4D),
        .regwriteW(regwriteW), .rdW(rdW), .resultW(resultW), .flushE(flushE),
        .rs1D(rs1D), .rs2D(rs2D), .regwriteE(regwriteE), .resultsrcE(resultsrcE),
        .memwriteE(memwriteE), .jumpE(jumpE), .branchE(branchE), .alucontrolE(alucontrolE),
        .alusrcE(alusrcE), .rd1E(rd1E), .rd2E(rd2E), .immextE(immextE), .pcE(pcE),
        .pcincr4E(pcincr4E), .rdE(rdE), .rs1E(rs1E), .rs2E(rs2E)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rdreg(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (regwriteW && rdW == a) return resultW;
        return mrf[a];
    endfunction

    function automatic int alufn(input logic [31:0] ins, input bit is_r);
        case (ins[14:12])
            3'd0: return (is_r && ins[30]) ? 1 : 0;
            3'd2: return 5;
            3'd6: return 3;
            3'd7: return 2;
            default: return 0;
        endcase
    endfunction

    function automatic exp_t model();
        exp_t e;
        int   sgn;
        e = '{default: '0};
        if (rst) return e;
        sgn = instrD[31] ? 1 : 0;
        case (instrD[6:0])
            7'h03: begin e.regw = 1; e.rsrc = 1; e.asrc = 1; e.imm = -2048*sgn + int'(instrD[30:20]); end
            7'h23: begin e.memw = 1; e.asrc = 1; e.imm = -2048*sgn + 32*int'(instrD[30:25]) + int'(instrD[11:7]); end
            7'h33: begin e.regw = 1; e.alu = 3'(alufn(instrD, 1)); end
            7'h13: begin e.regw = 1; e.asrc = 1; e.alu = 3'(alufn(instrD, 0));
                         e.imm = -2048*sgn + int'(instrD[30:20]); end
            7'h63: begin e.branch = 1; e.alu = 1;
                         e.imm = -4096*sgn + 2048*int'(instrD[7]) + 32*int'(instrD[30:25]) + 2*int'(instrD[11:8]); end
            7'h6f: begin e.regw = 1; e.jump = 1; e.rsrc = 2;
                         e.imm = -(1 << 20)*sgn + 4096*int'(instrD[19:12]) + 2048*int'(instrD[20]) + 2*int'(instrD[30:21]); end
            default: ;
        endcase
        e.rd1 = rdreg(instrD[19:15]);
        e.rd2 = rdreg(instrD[24:20]);
        e.pc = pcD; e.pc4 = pcincr4D;
        if (!flushE) begin
            e.rd = instrD[11:7]; e.rs1 = instrD[19:15]; e.rs2 = instrD[24:20];
        end else begin
            e.regw = 0; e.memw = 0; e.jump = 0; e.branch = 0; e.asrc = 0; e.rsrc = 0; e.alu = 0;
        end
        return e;
    endfunction

    // One clock: inputs are already driven; outputs checked on the next falling edge.
    task automatic step();
        exp_t e;
        e = model();
        chk("rs1D", 32'(rs1D), 32'(instrD[19:15]));
        chk("rs2D", 32'(rs2D), 32'(instrD[24:20]));
        @(posedge clk);
        if (rst) for (int i = 0; i < 32; i++) mrf[i] = 0;
        else if (regwriteW && rdW != 0) mrf[rdW] = resultW;
        @(negedge clk);
        chk("regwriteE", 32'(regwriteE), 32'(e.regw));
        chk("memwriteE", 32'(memwriteE), 32'(e.memw));
        chk("jumpE", 32'(jumpE), 32'(e.jump));
        chk("branchE", 32'(branchE), 32'(e.branch));
        chk("alusrcE", 32'(alusrcE), 32'(e.asrc));
        chk("resultsrcE", 32'(resultsrcE), 32'(e.rsrc));
        chk("alucontrolE", 32'(alucontrolE), 32'(e.alu));
        chk("rd1E", rd1E, e.rd1);
        chk("rd2E", rd2E, e.rd2);
        chk("immextE", immextE, e.imm);
        chk("pcE", pcE, e.pc);
        chk("pcincr4E", pcincr4E, e.pc4);
        chk("rdE", 32'(rdE), 32'(e.rd));
        chk("rs1E", 32'(rs1E), 32'(e.rs1));
        chk("rs2E", 32'(rs2E), 32'(e.rs2));
    endtask

    task automatic drive(input logic [31:0] ins, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic fl);
        instrD = ins; regwriteW = we; rdW = wa; resultW = wd; flushE = fl;
        pcD = $urandom & 32'hFFFF_FFFC; pcincr4D = pcD + 4;
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2, r1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, r2, r1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [7];
        logic [31:0] ins;
        ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h00};
        ins = $urandom;
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        ins[6:0] = ops[$urandom_range(0, 6)];
        if (ins[6:0] == 7'h00) ins[6:0] = 7'($urandom);
        return ins;
    endfunction

    logic [31:0] binstr, jinstr;
    logic [12:0] boff;
    logic [20:0] joff;

    initial begin
        for (int i = 0; i < 32; i++) mrf[i] = 0;
        rst = 1; drive(32'h0, 0, 0, 0, 0);
        @(negedge clk);
        // Reset with random instructions in flight
        drive($urandom, 1, 5'd5, $urandom, 0); step();
        drive($urandom, 0, 0, 0, 1); step();
        chk("reset_rd1E", rd1E, 32'd0);
        chk("reset_immextE", immextE, 32'd0);
        rst = 0;
        drive(enc_r(7'd0, 5'd0, 5'd5, 3'd0, 5'd1), 0, 0, 0, 0); step();
        chk("x5_after_reset", rd1E, 32'd0);

        // R-type sub
        drive(32'h13, 1, 5'd2, 32'd7, 0); step();
        drive(32'h13, 1, 5'd3, 32'd3, 0); step();
        drive(32'h403100B3, 0, 0, 0, 0); step();
        chk("sub_rd1E", rd1E, 32'd7);
        chk("sub_rd2E", rd2E, 32'd3);
        chk("sub_alu", 32'(alucontrolE), 32'd1);
        chk("sub_rdE", 32'(rdE), 32'd1);

        // Immediates
        drive(32'hFF812203, 0, 0, 0, 0); step();
        chk("lw_imm", immextE, 32'hFFFFFFF8);
        chk("lw_rsrc", 32'(resultsrcE), 32'd1);
        boff = 13'h1FFC;
        binstr = {boff[12], boff[10:5], 5'd3, 5'd2, 3'b000, boff[4:1], boff[11], 7'h63};
        drive(binstr, 0, 0, 0, 0); step();
        chk("beq_imm", immextE, 32'hFFFFFFFC);
        chk("beq_branch", 32'(branchE), 32'd1);
        joff = 21'd2048;
        jinstr = {joff[20], joff[10:1], joff[11], joff[19:12], 5'd1, 7'h6f};
        drive(jinstr, 0, 0, 0, 0); step();
        chk("jal_imm", immextE, 32'h00000800);
        chk("jal_rsrc", 32'(resultsrcE), 32'd2);

        // Write-through and x0
        drive(enc_r(7'd0, 5'd6, 5'd6, 3'd0, 5'd7), 1, 5'd6, 32'hDEADBEEF, 0); step();
        chk("wt_rd1E", rd1E, 32'hDEADBEEF);
        chk("wt_rd2E", rd2E, 32'hDEADBEEF);
        drive(enc_r(7'd0, 5'd0, 5'd0, 3'd0, 5'd1), 1, 5'd0, 32'h12345678, 0); step();
        chk("x0_wt", rd1E, 32'd0);
        drive(enc_r(7'd0, 5'd0, 5'd0, 3'd0, 5'd1), 0, 0, 0, 0); step();
        chk("x0_read", rd2E, 32'd0);

        // Flush with sw; concurrent write to x9 must commit
        drive({7'd0, 5'd3, 5'd2, 3'b010, 5'd4, 7'h23}, 1, 5'd9, 32'hA5A5_0009, 1); step();
        chk("flush_memw", 32'(memwriteE), 32'd0);
        drive(enc_r(7'd0, 5'd0, 5'd9, 3'd0, 5'd1), 0, 0, 0, 0); step();
        chk("flush_x9", rd1E, 32'hA5A5_0009);

        // Illegal opcode
        drive(32'h0000007F, 0, 0, 0, 0); step();
        chk("illegal_imm", immextE, 32'd0);
        chk("illegal_regw", 32'(regwriteE), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 99) < 2);
            drive(rand_instr(), 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 9) == 0));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
